// File: rtl/video_source_arbiter.sv
// Frame-boundary arbiter: forwards whole frames from one of two AXI4-Stream video
// sources into a single sink through a 2-entry skid buffer, with geometry checking.
module video_source_arbiter #(
  parameter int DATA_W    = 24,
  parameter int PIXELS    = 1920,
  parameter int LINES     = 1080,
  parameter bit DROP_IDLE = 1'b1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              sel,
  input  logic              err_clr,
  input  logic              s0_tvalid,
  input  logic              s0_tuser,
  input  logic              s0_tlast,
  input  logic [DATA_W-1:0] s0_tdata,
  output logic              s0_tready,
  input  logic              s1_tvalid,
  input  logic              s1_tuser,
  input  logic              s1_tlast,
  input  logic [DATA_W-1:0] s1_tdata,
  output logic              s1_tready,
  output logic              m_tvalid,
  output logic              m_tuser,
  output logic              m_tlast,
  output logic [DATA_W-1:0] m_tdata,
  input  logic              m_tready,
  output logic              active_src,
  output logic              locked,
  output logic [15:0]       frame_cnt,
  output logic              err_line,
  output logic              err_sof
);

  localparam int PW = $clog2(PIXELS + 1);
  localparam int LW = $clog2(LINES + 1);
  localparam int BW = DATA_W + 2;
  localparam logic [PW-1:0] PIX_MAX  = PW'(PIXELS);
  localparam logic [LW-1:0] LINE_MAX = LW'(LINES);

  typedef enum logic {SEEK = 1'b0, PASS = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            cur_q, cur_d;
  logic            locked_q, locked_d;
  logic [PW-1:0]   pix_q, pix_d;
  logic [LW-1:0]   line_q, line_d;
  logic [15:0]     frame_q, frame_d;
  logic            err_line_q, err_line_d;
  logic            err_sof_q, err_sof_d;
  logic [BW-1:0]   head_q, head_d;
  logic [BW-1:0]   tail_q, tail_d;
  logic [1:0]      cnt_q, cnt_d;

  logic            cur_tvalid;
  logic            cur_tuser;
  logic            cur_tlast;
  logic [BW-1:0]   cur_beat;
  logic            skid_ready;
  logic            acc;
  logic            push;
  logic            pop;
  logic            line_evt;
  logic            sof_evt;
  logic [PW-1:0]   pix_after;
  logic [LW-1:0]   line_base;
  logic [LW-1:0]   line_next;

  assign cur_tvalid = cur_q ? s1_tvalid : s0_tvalid;
  assign cur_tuser  = cur_q ? s1_tuser  : s0_tuser;
  assign cur_tlast  = cur_q ? s1_tlast  : s0_tlast;
  assign cur_beat   = cur_q ? {s1_tuser, s1_tlast, s1_tdata} : {s0_tuser, s0_tlast, s0_tdata};

  // Owned source sees skid space; the other one is either drained or stalled.
  assign skid_ready = (cnt_q != 2'd2);
  assign s0_tready  = cur_q ? DROP_IDLE : skid_ready;
  assign s1_tready  = cur_q ? skid_ready : DROP_IDLE;
  assign acc        = cur_tvalid && skid_ready;

  assign m_tvalid = (cnt_q != 2'd0);
  assign {m_tuser, m_tlast, m_tdata} = head_q;
  assign pop      = m_tvalid && m_tready;

  assign active_src = cur_q;
  assign locked     = locked_q;
  assign frame_cnt  = frame_q;
  assign err_line   = err_line_q;
  assign err_sof    = err_sof_q;

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    pix_d     = pix_q;
    line_d    = line_q;
    frame_d   = frame_q;
    push      = 1'b0;
    line_evt  = 1'b0;
    sof_evt   = 1'b0;
    pix_after = '0;
    line_base = '0;
    line_next = '0;

    if (state_q == SEEK) begin
      cur_d = sel;
      if (acc && cur_tuser) begin
        push    = 1'b1;
        state_d = PASS;
        cur_d   = cur_q;
      end
    end else if (acc) begin
      push = 1'b1;
    end

    if (push) begin
      // A tuser beat always restarts geometry; mid-frame it also flags an error.
      sof_evt   = (state_q == PASS) && cur_tuser && ((pix_q != '0) || (line_q != '0));
      pix_after = cur_tuser ? PW'(1) : pix_q + 1'b1;
      line_base = cur_tuser ? '0 : line_q;
      if (cur_tlast || (pix_after == PIX_MAX)) begin
        line_evt  = cur_tlast ? (pix_after != PIX_MAX) : 1'b1;
        pix_d     = '0;
        line_next = line_base + 1'b1;
      end else begin
        pix_d     = pix_after;
        line_next = line_base;
      end
      if (line_next == LINE_MAX) begin
        frame_d = frame_q + 16'd1;
        pix_d   = '0;
        line_d  = '0;
        if (sel != cur_q) begin
          state_d = SEEK;
          cur_d   = sel;
        end else begin
          state_d = PASS;
        end
      end else begin
        line_d = line_next;
      end
    end

    err_line_d = (err_line_q && !err_clr) || line_evt;
    err_sof_d  = (err_sof_q && !err_clr) || sof_evt;
    locked_d   = (state_d == PASS);
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_d = cur_beat;
          cnt_d  = 2'd1;
        end else begin
          tail_d = cur_beat;
          cnt_d  = 2'd2;
        end
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: head_d = cur_beat;
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= SEEK;
      cur_q      <= 1'b0;
      locked_q   <= 1'b0;
      pix_q      <= '0;
      line_q     <= '0;
      frame_q    <= '0;
      err_line_q <= 1'b0;
      err_sof_q  <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      locked_q   <= locked_d;
      pix_q      <= pix_d;
      line_q     <= line_d;
      frame_q    <= frame_d;
      err_line_q <= err_line_d;
      err_sof_q  <= err_sof_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_video_source_arbiter.sv
// Scoreboard bench for video_source_arbiter with a 4x3 frame geometry; expected beats
// are queued at issue time and checked by an independent output monitor.
module tb_video_source_arbiter;

  localparam int DW = 24;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          sel = 1'b0;
  logic          err_clr = 1'b0;
  logic          s0_tvalid = 1'b0, s0_tuser = 1'b0, s0_tlast = 1'b0;
  logic [DW-1:0] s0_tdata = '0;
  logic          s0_tready;
  logic          s1_tvalid = 1'b0, s1_tuser = 1'b0, s1_tlast = 1'b0;
  logic [DW-1:0] s1_tdata = '0;
  logic          s1_tready;
  logic          m_tvalid, m_tuser, m_tlast;
  logic [DW-1:0] m_tdata;
  logic          m_tready = 1'b1;
  logic          active_src, locked;
  logic [15:0]   frame_cnt;
  logic          err_line, err_sof;

  int            errors = 0;
  int            checks = 0;
  int            out_cnt = 0;
  bit            rand_ready = 1'b0;
  bit            ready_force = 1'b1;
  logic [DW+1:0] exp_q[$];

  video_source_arbiter #(.DATA_W(DW), .PIXELS(4), .LINES(3), .DROP_IDLE(1'b1)) dut (
    .aclk(aclk), .aresetn(aresetn), .sel(sel), .err_clr(err_clr),
    .s0_tvalid(s0_tvalid), .s0_tuser(s0_tuser), .s0_tlast(s0_tlast),
    .s0_tdata(s0_tdata), .s0_tready(s0_tready),
    .s1_tvalid(s1_tvalid), .s1_tuser(s1_tuser), .s1_tlast(s1_tlast),
    .s1_tdata(s1_tdata), .s1_tready(s1_tready),
    .m_tvalid(m_tvalid), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tdata(m_tdata), .m_tready(m_tready),
    .active_src(active_src), .locked(locked), .frame_cnt(frame_cnt),
    .err_line(err_line), .err_sof(err_sof)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    #1;
    m_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Output monitor: pops on every sink handshake and checks hold-under-stall.
  initial begin
    logic [DW+1:0] got, prev_beat, e;
    bit prev_stall;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        prev_stall = 1'b0;
        continue;
      end
      got = {m_tuser, m_tlast, m_tdata};
      if (prev_stall) begin
        checks++;
        if (!m_tvalid || got != prev_beat) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b beat=%h, required valid=1 beat=%h",
                   m_tvalid, got, prev_beat);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        out_cnt++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h, required no output", got);
        end else begin
          e = exp_q.pop_front();
          if (got != e) begin
            errors++;
            $display("FAIL out_beat %0d: got %h, required %h", out_cnt, got, e);
          end else begin
            $display("out %0d: user=%0b last=%0b data=%h", out_cnt, m_tuser, m_tlast, m_tdata);
          end
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = got;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic send(input bit src, input logic [DW-1:0] d, input bit u, input bit l,
                      input bit fwd, input int gap);
    int n;
    if (src) begin
      s1_tvalid = 1'b1; s1_tdata = d; s1_tuser = u; s1_tlast = l;
    end else begin
      s0_tvalid = 1'b1; s0_tdata = d; s0_tuser = u; s0_tlast = l;
    end
    if (fwd) exp_q.push_back({u, l, d});
    n = 0;
    forever begin
      @(negedge aclk);
      if (src ? s1_tready : s0_tready) break;
      n++;
      if (n > 1000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got no tready, required accept of %h", d);
        break;
      end
    end
    @(posedge aclk);
    #1;
    s0_tvalid = 1'b0; s0_tuser = 1'b0; s0_tlast = 1'b0;
    s1_tvalid = 1'b0; s1_tuser = 1'b0; s1_tlast = 1'b0;
    repeat (gap) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send_frame(input bit src, input logic [DW-1:0] base, input bit rnd);
    for (int i = 0; i < 12; i++)
      send(src, rnd ? DW'($urandom) : base + DW'(i), i == 0, (i % 4) == 3, 1'b1,
           rnd ? $urandom_range(0, 2) : 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge aclk);
      n++;
    end
    repeat (3) @(posedge aclk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    // Reset with both sources presenting beats
    s0_tvalid = 1'b1; s1_tvalid = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_locked", locked, 0);
    chk("rst_s0_tready", s0_tready, 1);
    chk("rst_s1_tready", s1_tready, 1);
    s0_tvalid = 1'b0; s1_tvalid = 1'b0;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Junk before SOF is dropped, then one full frame from s0
    for (int i = 0; i < 3; i++) send(1'b0, 24'hBAD000 + DW'(i), 1'b0, i == 1, 1'b0, 0);
    chk("seek_locked", locked, 0);
    send(1'b0, 24'h000100, 1'b1, 1'b0, 1'b1, 0);
    chk("sof_latency_valid", m_tvalid, 1);
    chk("sof_latency_user", m_tuser, 1);
    chk("sof_latency_data", m_tdata, 24'h000100);
    for (int i = 1; i < 12; i++) send(1'b0, 24'h000100 + DW'(i), 1'b0, (i % 4) == 3, 1'b1, 0);
    chk("f1_frame_cnt", frame_cnt, 1);
    chk("f1_locked", locked, 1);
    drain();
    chk("f1_out_cnt", out_cnt, 12);

    // sel moves to 1 mid-frame; switch only at frame end
    for (int i = 0; i < 12; i++) begin
      if (i == 4) sel = 1'b1;
      send(1'b0, 24'h000200 + DW'(i), i == 0, (i % 4) == 3, 1'b1, 0);
      if (i == 8) chk("sw_mid_active", active_src, 0);
    end
    chk("sw_active_src", active_src, 1);
    chk("sw_locked", locked, 0);
    chk("sw_frame_cnt", frame_cnt, 2);
    chk("sw_s0_dropready", s0_tready, 1);
    send_frame(1'b1, 24'h000300, 1'b0);
    chk("s1_frame_cnt", frame_cnt, 3);
    chk("s1_locked", locked, 1);
    drain();

    // Random sink backpressure and source gaps over four frames
    rand_ready = 1'b1;
    for (int f = 0; f < 4; f++) send_frame(1'b1, '0, 1'b1);
    chk("rnd_frame_cnt", frame_cnt, 7);
    rand_ready = 1'b0;
    drain();

    // Short line 2 -> err_line; then clear
    for (int i = 0; i < 4; i++) send(1'b1, 24'h000400 + DW'(i), i == 0, i == 3, 1'b1, 0);
    chk("pre_err_line", err_line, 0);
    for (int i = 0; i < 3; i++) send(1'b1, 24'h000410 + DW'(i), 1'b0, i == 2, 1'b1, 0);
    chk("short_err_line", err_line, 1);
    for (int i = 0; i < 4; i++) send(1'b1, 24'h000420 + DW'(i), 1'b0, i == 3, 1'b1, 0);
    chk("short_frame_cnt", frame_cnt, 8);
    err_clr = 1'b1;
    @(posedge aclk);
    #1;
    err_clr = 1'b0;
    chk("clr_err_line", err_line, 0);

    // Mid-frame tuser on beat 6 -> err_sof, resync, truncated frame not counted
    for (int i = 0; i < 5; i++) send(1'b1, 24'h000500 + DW'(i), i == 0, i == 3, 1'b1, 0);
    for (int i = 0; i < 12; i++) begin
      send(1'b1, 24'h000600 + DW'(i), i == 0, (i % 4) == 3, 1'b1, 0);
      if (i == 0) begin
        chk("sof_err_sof", err_sof, 1);
        chk("sof_frame_cnt_hold", frame_cnt, 8);
      end
    end
    chk("resync_frame_cnt", frame_cnt, 9);
    chk("resync_err_line", err_line, 0);
    drain();

    // Mid-frame reset with skid full
    ready_force = 1'b0;
    repeat (2) begin
      @(posedge aclk);
      #1;
    end
    send(1'b1, 24'h000700, 1'b1, 1'b0, 1'b0, 0);
    send(1'b1, 24'h000701, 1'b0, 1'b0, 1'b0, 0);
    chk("full_s1_tready", s1_tready, 0);
    s1_tvalid = 1'b1; s1_tdata = 24'h000702;
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    chk("mrst_m_tvalid", m_tvalid, 0);
    chk("mrst_locked", locked, 0);
    chk("mrst_active_src", active_src, 0);
    chk("mrst_frame_cnt", frame_cnt, 0);
    chk("mrst_err_sof", err_sof, 0);
    s1_tvalid = 1'b0;
    ready_force = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
    chk("end_queue_empty", exp_q.size(), 0);
    chk("end_m_tvalid", m_tvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
